// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-RAM arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RD_WAIT
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } owner_t;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between CPU and DBG requests.
// DMEM_ARB_RR_EN: round-robin on ties; otherwise fixed CPU priority.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  owner_t last_owner,
    output owner_t winner,
    output logic   any_req
);

    always_comb begin
        any_req = cpu_req | dbg_req;
        // With no request the winner is never used; last_owner is a harmless fallback.
        winner  = cpu_req ? OWN_CPU : (dbg_req ? OWN_DBG : last_owner);
`ifdef DMEM_ARB_RR_EN
        if (cpu_req && dbg_req) begin
            winner = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the CPU load/store path and the debug/loader port.
// Build option DMEM_ARB_RR_EN selects round-robin tie-breaking in dmem_arb_pick.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t     state;
    owner_t     owner;
    owner_t     lastOwner;
    owner_t     winner;
    logic       anyReq;
    logic [1:0] latCnt;

    dmem_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .last_owner (lastOwner),
        .winner     (winner),
        .any_req    (anyReq)
    );

    assign busy = (state != IDLE);

    // ram_addr/ram_wdata double as the captured request registers, and ram_we
    // holds the captured direction during ACCESS.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_DBG;
            lastOwner  <= OWN_DBG;
            latCnt     <= '0;
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
        end else begin
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            ram_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        owner     <= winner;
                        lastOwner <= winner;
                        state     <= ACCESS;
                        if (winner == OWN_CPU) begin
                            ram_addr  <= cpu_addr;
                            ram_wdata <= cpu_wdata;
                            ram_we    <= cpu_we;
                            cpu_gnt   <= 1'b1;
                        end else begin
                            ram_addr  <= dbg_addr;
                            ram_wdata <= dbg_wdata;
                            ram_we    <= dbg_we;
                            dbg_gnt   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (ram_we) begin
                        state <= IDLE;
                    end else begin
                        latCnt <= LAT_INIT;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (latCnt != 2'd0) begin
                        latCnt <= latCnt - 2'd1;
                    end else begin
                        state <= IDLE;
                        if (owner == OWN_CPU) begin
                            cpu_rdata  <= ram_rdata;
                            cpu_rvalid <= 1'b1;
                        end else begin
                            dbg_rdata  <= ram_rdata;
                            dbg_rvalid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: RD_LAT=1 (instance 0) and RD_LAT=3 (instance 1) with RAM models.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        cpuReq[2], cpuWe[2], dbgReq[2], dbgWe[2];
    logic [7:0]  cpuAddr[2], dbgAddr[2], ramAddr[2];
    logic [15:0] cpuWdata[2], dbgWdata[2], cpuRdata[2], dbgRdata[2], ramWdata[2], ramRdata[2];
    logic        cpuGnt[2], cpuRvalid[2], dbgGnt[2], dbgRvalid[2], ramWe[2], busy[2];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dutA (
        .clock(clock), .reset(reset),
        .cpu_req(cpuReq[0]), .cpu_we(cpuWe[0]), .cpu_addr(cpuAddr[0]), .cpu_wdata(cpuWdata[0]),
        .cpu_gnt(cpuGnt[0]), .cpu_rvalid(cpuRvalid[0]), .cpu_rdata(cpuRdata[0]),
        .dbg_req(dbgReq[0]), .dbg_we(dbgWe[0]), .dbg_addr(dbgAddr[0]), .dbg_wdata(dbgWdata[0]),
        .dbg_gnt(dbgGnt[0]), .dbg_rvalid(dbgRvalid[0]), .dbg_rdata(dbgRdata[0]),
        .ram_addr(ramAddr[0]), .ram_wdata(ramWdata[0]), .ram_we(ramWe[0]),
        .ram_rdata(ramRdata[0]), .busy(busy[0])
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3)) dutB (
        .clock(clock), .reset(reset),
        .cpu_req(cpuReq[1]), .cpu_we(cpuWe[1]), .cpu_addr(cpuAddr[1]), .cpu_wdata(cpuWdata[1]),
        .cpu_gnt(cpuGnt[1]), .cpu_rvalid(cpuRvalid[1]), .cpu_rdata(cpuRdata[1]),
        .dbg_req(dbgReq[1]), .dbg_we(dbgWe[1]), .dbg_addr(dbgAddr[1]), .dbg_wdata(dbgWdata[1]),
        .dbg_gnt(dbgGnt[1]), .dbg_rvalid(dbgRvalid[1]), .dbg_rdata(dbgRdata[1]),
        .ram_addr(ramAddr[1]), .ram_wdata(ramWdata[1]), .ram_we(ramWe[1]),
        .ram_rdata(ramRdata[1]), .busy(busy[1])
    );

    // RAM models: latency 1 and latency 3, with a bench-side preload port
    logic [15:0] memA[256], memB[256];
    logic [15:0] pipeA, pipeB[3];
    logic        preWe, preInst;
    logic [7:0]  preAddr;
    logic [15:0] preData;

    always @(posedge clock) begin
        if (preWe && !preInst) memA[preAddr] <= preData;
        else if (ramWe[0]) memA[ramAddr[0]] <= ramWdata[0];
        pipeA <= memA[ramAddr[0]];
    end
    always @(posedge clock) begin
        if (preWe && preInst) memB[preAddr] <= preData;
        else if (ramWe[1]) memB[ramAddr[1]] <= ramWdata[1];
        pipeB[0] <= memB[ramAddr[1]];
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign ramRdata[0] = pipeA;
    assign ramRdata[1] = pipeB[2];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } exp_t;
    exp_t qA[$], qB[$];

    typedef struct {
        int          inst;
        logic        port;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[9];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Completed reads are popped from the scoreboard in grant order
    function automatic void monitor();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (cpuRvalid[i] || dbgRvalid[i]) begin
                if ((i == 0 && qA.size() == 0) || (i == 1 && qB.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid inst=%0d actual=1 required=0", i);
                end else begin
                    e = (i == 0) ? qA.pop_front() : qB.pop_front();
                    chk("rv_port", 32'(dbgRvalid[i]), 32'(e.port));
                    chk("rv_data", 32'(e.port ? dbgRdata[i] : cpuRdata[i]), 32'(e.data));
                    chk("rv_both", 32'(cpuRvalid[i] & dbgRvalid[i]), 32'd0);
                end
            end
        end
    endfunction

    task automatic step();
        @(negedge clock);
        monitor();
    endtask

    task automatic setReq(int i, logic p, logic rq, logic we, logic [7:0] a, logic [15:0] d);
        if (!p) begin
            cpuReq[i] = rq; cpuWe[i] = we; cpuAddr[i] = a; cpuWdata[i] = d;
        end else begin
            dbgReq[i] = rq; dbgWe[i] = we; dbgAddr[i] = a; dbgWdata[i] = d;
        end
    endtask

    function automatic logic gntOf(int i, logic p);
        return p ? dbgGnt[i] : cpuGnt[i];
    endfunction

    function automatic logic rvOf(int i, logic p);
        return p ? dbgRvalid[i] : cpuRvalid[i];
    endfunction

    task automatic txn(int i, logic p, logic we, logic [7:0] a, logic [15:0] d, logic [15:0] expRd, int lat);
        exp_t e;
        int   n;
        setReq(i, p, 1'b1, we, a, d);
        step();
        chk("gnt", 32'(gntOf(i, p)), 32'd1);
        chk("gnt_other", 32'(gntOf(i, !p)), 32'd0);
        chk("ram_we", 32'(ramWe[i]), 32'(we));
        chk("ram_addr", 32'(ramAddr[i]), 32'(a));
        if (we) chk("ram_wdata", 32'(ramWdata[i]), 32'(d));
        chk("busy_access", 32'(busy[i]), 32'd1);
        setReq(i, p, 1'b0, we, a, d);
        if (we) begin
            step();
            chk("we_pulse", 32'(ramWe[i]), 32'd0);
            chk("busy_after_wr", 32'(busy[i]), 32'd0);
        end else begin
            e.port = p;
            e.data = expRd;
            if (i == 0) qA.push_back(e); else qB.push_back(e);
            n = 0;
            do begin
                step();
                n++;
                chk("busy_rd", 32'(busy[i]), 32'(!rvOf(i, p)));
            end while (!rvOf(i, p) && n < 10);
            chk("rd_lat", 32'(n), 32'(lat + 1));
        end
    endtask

    logic [1:0] order[16];
    int         nOrd, cpuLeft, dbgLeft, dbgCount;
    logic       cpuHold, dbgHold;

    initial begin
        reset = 1'b0;
        preWe = 1'b0; preInst = 1'b0; preAddr = '0; preData = '0;
        for (int i = 0; i < 2; i++) begin
            setReq(i, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
            setReq(i, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        end
        vecs[0] = '{0, 1'b0, 1'b1, 8'h10, 16'h1234, 16'h0000};
        vecs[1] = '{0, 1'b0, 1'b0, 8'h10, 16'h0000, 16'h1234};
        vecs[2] = '{0, 1'b1, 1'b1, 8'h11, 16'hCAFE, 16'h0000};
        vecs[3] = '{0, 1'b0, 1'b0, 8'h11, 16'h0000, 16'hCAFE};
        vecs[4] = '{0, 1'b0, 1'b1, 8'hFF, 16'hFFFF, 16'h0000};
        vecs[5] = '{0, 1'b1, 1'b0, 8'hFF, 16'h0000, 16'hFFFF};
        vecs[6] = '{1, 1'b1, 1'b0, 8'h05, 16'h0000, 16'hBEEF};
        vecs[7] = '{1, 1'b0, 1'b1, 8'h00, 16'h8001, 16'h0000};
        vecs[8] = '{1, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h8001};

        // Reset held low while the latency-3 RAM is preloaded
        @(negedge clock);
        preWe = 1'b1; preInst = 1'b1; preAddr = 8'h05; preData = 16'hBEEF;
        step();
        preWe = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_gnt", 32'({cpuGnt[i], dbgGnt[i]}), 32'd0);
            chk("rst_rvalid", 32'({cpuRvalid[i], dbgRvalid[i]}), 32'd0);
            chk("rst_rdata", {cpuRdata[i], dbgRdata[i]}, 32'd0);
            chk("rst_ram", {ramAddr[i], ramWdata[i], 7'd0, ramWe[i]}, 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
        end
        reset = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("idle_gnt", 32'({cpuGnt[i], dbgGnt[i]}), 32'd0);
            chk("idle_busy", 32'(busy[i]), 32'd0);
        end

        for (int v = 0; v < 9; v++) begin
            txn(vecs[v].inst, vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                vecs[v].exp, (vecs[v].inst == 1) ? 3 : 1);
        end

        // Both ports re-request continuously, four reads each
        cpuLeft = 4; dbgLeft = 4; cpuHold = 1'b0; dbgHold = 1'b0; nOrd = 0;
        setReq(0, 1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
        setReq(0, 1'b1, 1'b1, 1'b0, 8'h11, 16'h0000);
        for (int c = 0; c < 200 && (cpuLeft > 0 || dbgLeft > 0 || qA.size() > 0); c++) begin
            exp_t e;
            step();
            if (cpuGnt[0]) begin
                if (nOrd < 16) order[nOrd] = 2'd0;
                nOrd++; cpuLeft--; cpuReq[0] = 1'b0; cpuHold = 1'b1;
                e.port = 1'b0; e.data = 16'h1234; qA.push_back(e);
            end else if (cpuHold) begin
                cpuHold = 1'b0; cpuReq[0] = (cpuLeft > 0);
            end
            if (dbgGnt[0]) begin
                if (nOrd < 16) order[nOrd] = 2'd1;
                nOrd++; dbgLeft--; dbgReq[0] = 1'b0; dbgHold = 1'b1;
                e.port = 1'b1; e.data = 16'hCAFE; qA.push_back(e);
            end else if (dbgHold) begin
                dbgHold = 1'b0; dbgReq[0] = (dbgLeft > 0);
            end
        end
        cpuReq[0] = 1'b0; dbgReq[0] = 1'b0;
        chk("stress_grants", 32'(nOrd), 32'd8);
        chk("stress_drain", 32'(qA.size()), 32'd0);
        for (int k = 0; k < 8; k++) begin
`ifdef DMEM_ARB_RR_EN
            chk("grant_order", 32'(order[k]), 32'(k % 2));
`else
            chk("grant_order", 32'(order[k]), 32'(k >= 4));
`endif
        end

        // Reset in RD_WAIT abandons the read
        setReq(1, 1'b0, 1'b1, 1'b0, 8'h05, 16'h0000);
        step();
        chk("abort_gnt", 32'(cpuGnt[1]), 32'd1);
        cpuReq[1] = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("abort_rvalid", 32'(cpuRvalid[1]), 32'd0);
        chk("abort_we", 32'(ramWe[1]), 32'd0);
        chk("abort_busy", 32'(busy[1]), 32'd0);
        chk("abort_rdata", 32'(cpuRdata[1]), 32'd0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("abort_quiet", 32'({cpuRvalid[1], busy[1]}), 32'd0);
        end
        txn(1, 1'b1, 1'b1, 8'h20, 16'h5A5A, 16'h0000, 3);
        txn(1, 1'b1, 1'b0, 8'h20, 16'h0000, 16'h5A5A, 3);

        // DBG request rising during a CPU ACCESS waits for IDLE
        setReq(0, 1'b0, 1'b1, 1'b1, 8'h30, 16'h0F0F);
        step();
        chk("late_cpu_gnt", 32'(cpuGnt[0]), 32'd1);
        cpuReq[0] = 1'b0;
        setReq(0, 1'b1, 1'b1, 1'b1, 8'h31, 16'h7777);
        step();
        chk("late_idle_busy", 32'(busy[0]), 32'd0);
        chk("late_early_gnt", 32'(dbgGnt[0]), 32'd0);
        step();
        chk("late_dbg_gnt", 32'(dbgGnt[0]), 32'd1);
        chk("late_ram", {ramAddr[0], ramWdata[0], 7'd0, ramWe[0]}, {8'h31, 16'h7777, 8'h01});
        dbgReq[0] = 1'b0;
        dbgCount = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            dbgCount += int'(dbgGnt[0]);
        end
        chk("late_no_dup", 32'(dbgCount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data RAM between the processor's LOAD/STORE path (CPU port) and a debug/loader port (DBG port).
- Accepts one request at a time, sequences the RAM access with the RAM's synchronous read latency, and returns read data with a one-cycle valid pulse.
- Sits between the requesters and the data RAM instance.

Parameters:
ADDR_W, 8, RAM word-address width.
DATA_W, 16, RAM data width.
RD_LAT, 1, RAM read latency in clock edges from the address sample to valid q; legal range 1..3.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  reset, synchronous, active-low; clock clock.
cpu_req  in  1  CPU access request; held until cpu_gnt seen.
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high.
cpu_addr  in  ADDR_W  CPU word address.
cpu_wdata  in  DATA_W  CPU write data.
cpu_gnt  out  1  one-cycle pulse: CPU request accepted.
cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
cpu_rdata  out  DATA_W  CPU read data; holds until the next CPU read completes.
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* set, for the DBG port.
ram_addr  out  ADDR_W  RAM address (captured request address).
ram_wdata  out  DATA_W  RAM write data.
ram_we  out  1  RAM write enable.
ram_rdata  in  DATA_W  RAM q output.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset==0 at posedge) forces:
  - state IDLE, last_owner=DBG;
  - all gnt/rvalid low; all rdata 0; ram_addr/ram_wdata 0; ram_we 0; busy 0.
- Reset during ACCESS or RD_WAIT abandons the access: no rvalid, no further ram_we.
- States: IDLE, ACCESS, RD_WAIT.
- IDLE:
  - If any req is high, pick the winner.
  - At the edge: capture the winner's addr/we/wdata into owner/addr/we/wdata registers, go to ACCESS.
  - The winner's gnt is high for exactly the ACCESS cycle (registered).
  - With no req, stay in IDLE.
- ACCESS (1 cycle):
  - ram_addr/ram_wdata come from the captured registers.
  - ram_we = captured we; it is high for this one cycle only.
  - Write: next state IDLE.
  - Read: load lat_cnt=RD_LAT-1, next state RD_WAIT.
- RD_WAIT:
  - ram_addr held, ram_we 0.
  - While lat_cnt!=0: decrement.
  - When lat_cnt==0: register ram_rdata into the owner's rdata, pulse the owner's rvalid next cycle, go to IDLE.
- Latency, with the request first seen in IDLE at cycle T:
  - gnt at T+1.
  - RAM write at T+1.
  - rvalid/rdata at T+2+RD_LAT.
  - Write occupancy 2 cycles; read occupancy 2+RD_LAT cycles.
- Requester rules:
  - Requester deasserts req in the cycle after gnt; the arbiter ignores req outside IDLE.
  - A req that rises outside IDLE waits and is served on return to IDLE.
  - A req still high in IDLE is treated as a new request.
- Arbitration without the macro: fixed priority, CPU wins when both request.
- last_owner is updated on every grant.
- rvalid of the non-owner is never asserted; both rvalids are never high together.
- Widths are pass-through; no arithmetic beyond lat_cnt (2 bits). There is no address range check.

Optional Feature:
DMEM_ARB_RR_EN
- Defined: round-robin. When both request in the same IDLE cycle, the port that is not last_owner wins. After reset the CPU wins the first tie, because last_owner resets to DBG.
- Single requests are unaffected.
- Undefined: fixed CPU priority as above; last_owner is still maintained but unused.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum for state (IDLE, ACCESS, RD_WAIT);
  - typedef enum owner_t (OWN_CPU, OWN_DBG);
  - default width constants ADDR_W_DEF=8, DATA_W_DEF=16.
- One combinational sub-module, dmem_arb_pick: inputs cpu_req, dbg_req, last_owner; outputs winner and any_req. Holds the DMEM_ARB_RR_EN conditional.
- FSM, capture registers and latency counter live in dmem_arbiter.

Test Plan:
1. Hold reset low 2 cycles, then release -> every output 0, busy 0; one idle cycle produces no gnt.
2. CPU write addr 0x10, data 0x1234 at T -> cpu_gnt at T+1; ram_we=1 at T+1 only with ram_addr=0x10, ram_wdata=0x1234. Then CPU read 0x10 -> cpu_rvalid at T'+3 with cpu_rdata=0x1234; dbg_rvalid stays 0.
3. Both ports request continuously 4 times (deassert after gnt, reassert next cycle) -> without macro, CPU granted 4 times before DBG; with DMEM_ARB_RR_EN, grant order CPU,DBG,CPU,DBG.
4. RD_LAT=3 instance, DBG read of 0x05 preloaded with 0xBEEF -> dbg_gnt at T+1, dbg_rvalid at T+5 with 0xBEEF; busy high T+1..T+4.
5. CPU read started, reset driven low during RD_WAIT -> no cpu_rvalid, ram_we 0, state IDLE. After release, a DBG write to 0x20 completes normally.
6. DBG req rises during a CPU ACCESS cycle -> dbg_gnt exactly 1 cycle after the arbiter returns to IDLE; no dropped or duplicated grant.
